// File: rtl/gpc_accumulator_if.sv
// Beat/result handshake bundle for gpc_accumulator.
// slave is the accumulator's view; master is the producer/consumer side.
interface gpc_accumulator_if #(
   parameter int unsigned N_OPS  = 6,
   parameter int unsigned OP_W   = 8,
   parameter int unsigned ACC_W  = 24,
   parameter int unsigned BEAT_W = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic [N_OPS*OP_W-1:0]   in_ops;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic [ACC_W-1:0]        out_sum;
   logic [BEAT_W-1:0]       out_beats;
   logic                    out_ovf;

   modport master (
      output in_valid,
      output in_ops,
      output in_last,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_sum,
      input  out_beats,
      input  out_ovf
   );

   modport slave (
      input  in_valid,
      input  in_ops,
      input  in_last,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_sum,
      output out_beats,
      output out_ovf
   );
endinterface

// File: rtl/gpc_accumulator.sv
// Streaming multi-operand frame accumulator: carry-save compression stage, then carry-propagate
// fold into a running sum. Define GPC_ACC_SAT_EN to clamp the accumulator instead of wrapping.
module gpc_accumulator #(
   parameter int unsigned N_OPS  = 6,
   parameter int unsigned OP_W   = 8,
   parameter int unsigned ACC_W  = 24,
   parameter int unsigned BEAT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gpc_accumulator_if.slave     bus_io
);

   localparam int unsigned SumW = OP_W + $clog2(N_OPS);

   if (N_OPS < 2 || N_OPS > 16) begin : g_bad_n_ops
      $error("gpc_accumulator: N_OPS must be in 2..16");
   end
   if (ACC_W < SumW) begin : g_bad_acc_w
      $error("gpc_accumulator: ACC_W must be at least OP_W + clog2(N_OPS)");
   end

   typedef enum logic [1:0] {StInit, StAccum, StFlush, StHold} state_e;

   state_e            state_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              accept;
   logic              handshake;

   logic [SumW-1:0]   tree_sum;
   logic [SumW-1:0]   tree_carry;
   logic              s1_vld_q;
   logic [SumW-1:0]   s1_sum_q;
   logic [SumW-1:0]   s1_carry_q;

   logic [SumW-1:0]   beat_total;
   logic [ACC_W:0]    acc_ext;
   logic              acc_carry;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [BEAT_W-1:0] beats_q, beats_d;
   logic              ovf_q, ovf_d;

   // in_ready_q is only high in StAccum, so it alone qualifies acceptance.
   assign accept    = bus_io.in_valid && in_ready_q;
   assign handshake = out_valid_q && bus_io.out_ready;

   // ---------------------------------------------------------------------------------------------
   // Control FSM with registered handshake outputs
   // ---------------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StInit;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            StInit: begin
               state_q    <= StAccum;
               in_ready_q <= 1'b1;
            end
            StAccum: begin
               if (accept && bus_io.in_last) begin
                  state_q    <= StFlush;
                  in_ready_q <= 1'b0;
               end
            end
            StFlush: begin
               state_q     <= StHold;
               out_valid_q <= 1'b1;
            end
            StHold: begin
               if (bus_io.out_ready) begin
                  state_q     <= StAccum;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= StInit;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Stage 1: array of (3;2) counters folding each operand into a sum/carry pair
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      logic [SumW-1:0] s;
      logic [SumW-1:0] c;
      logic [SumW-1:0] x;
      logic [SumW-1:0] t;
      s = SumW'(bus_io.in_ops[0 +: OP_W]);
      c = SumW'(bus_io.in_ops[OP_W +: OP_W]);
      x = '0;
      t = '0;
      for (int i = 2; i < int'(N_OPS); i++) begin
         x = SumW'(bus_io.in_ops[i*OP_W +: OP_W]);
         t = s ^ c ^ x;
         // Dropped MSB of the shifted carry is harmless: the beat total always fits in SumW.
         c = ((s & c) | (s & x) | (c & x)) << 1;
         s = t;
      end
      tree_sum   = s;
      tree_carry = c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q   <= 1'b0;
         s1_sum_q   <= '0;
         s1_carry_q <= '0;
      end else begin
         s1_vld_q <= accept;
         if (accept) begin
            s1_sum_q   <= tree_sum;
            s1_carry_q <= tree_carry;
         end
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Stage 2: carry-propagate fold into the frame accumulator
   // ---------------------------------------------------------------------------------------------
   assign beat_total = s1_sum_q + s1_carry_q;
   assign acc_ext    = {1'b0, acc_q} + {{(ACC_W + 1 - SumW){1'b0}}, beat_total};
   assign acc_carry  = acc_ext[ACC_W];

   always_comb begin
      acc_d   = acc_q;
      beats_d = beats_q;
      ovf_d   = ovf_q;
      if (handshake) begin
         acc_d   = '0;
         beats_d = '0;
         ovf_d   = 1'b0;
      end else if (s1_vld_q) begin
`ifdef GPC_ACC_SAT_EN
         // Once clamped, any further non-zero beat carries again, so the sum stays all-ones.
         acc_d = acc_carry ? {ACC_W{1'b1}} : acc_ext[ACC_W-1:0];
`else
         acc_d = acc_ext[ACC_W-1:0];
`endif
         beats_d = (beats_q == {BEAT_W{1'b1}}) ? beats_q : beats_q + 1'b1;
         ovf_d   = ovf_q | acc_carry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         beats_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         beats_q <= beats_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus_io.in_ready  = in_ready_q;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_sum   = acc_q;
   assign bus_io.out_beats = beats_q;
   assign bus_io.out_ovf   = ovf_q;

endmodule

// File: tb/tb_gpc_accumulator.sv
// Self-checking bench for gpc_accumulator: frame-level model checked every cycle, plus
// hand-computed literal expectations per directed frame.
module tb_gpc_accumulator;

   localparam int unsigned NOps  = 6;
   localparam int unsigned OpW   = 8;
   localparam int unsigned AccW  = 12;
   localparam int unsigned BeatW = 2;
   localparam int          AccMax  = (1 << AccW) - 1;
   localparam int          BeatMax = (1 << BeatW) - 1;

   localparam logic [47:0] OpsFf  = {48{1'b1}};
   localparam logic [47:0] OpsSeq = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
   localparam logic [47:0] OpsOne = {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
   localparam logic [47:0] OpsTen = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd10};

`ifdef GPC_ACC_SAT_EN
   localparam logic [11:0] OvfSum = 12'hFFF;
`else
   localparam logic [11:0] OvfSum = 12'h1EE;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   gpc_accumulator_if #(.N_OPS(NOps), .OP_W(OpW), .ACC_W(AccW), .BEAT_W(BeatW)) bus ();

   gpc_accumulator #(
      .N_OPS (NOps),
      .OP_W  (OpW),
      .ACC_W (AccW),
      .BEAT_W(BeatW)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus_io(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // ---------------------------------------------------------------------------------------------
   // Frame-level model: total of all accepted operands and count of accepted beats
   // ---------------------------------------------------------------------------------------------
   bit m_init, m_ready, m_flush, m_valid;
   int m_total, m_n;

   function automatic int opsum(input logic [47:0] v);
      int s;
      s = 0;
      for (int i = 0; i < 6; i++) s += int'(v[i*8 +: 8]);
      return s;
   endfunction

   function automatic int exp_sum(input int total);
`ifdef GPC_ACC_SAT_EN
      return (total > AccMax) ? AccMax : total;
`else
      return total % (AccMax + 1);
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_init <= 1'b1; m_ready <= 1'b0; m_flush <= 1'b0; m_valid <= 1'b0;
         m_total <= 0; m_n <= 0;
      end else begin
         if (m_init) begin
            m_init <= 1'b0; m_ready <= 1'b1;
         end
         if (m_ready && bus.in_valid) begin
            m_total <= m_total + opsum(bus.in_ops);
            m_n     <= m_n + 1;
            if (bus.in_last) begin
               m_ready <= 1'b0; m_flush <= 1'b1;
            end
         end
         if (m_flush) begin
            m_flush <= 1'b0; m_valid <= 1'b1;
         end
         if (m_valid && bus.out_ready) begin
            m_valid <= 1'b0; m_ready <= 1'b1; m_total <= 0; m_n <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
         chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
         chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
      end else begin
         chk("in_ready", 32'(bus.in_ready), 32'(m_ready));
         chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
         if (m_valid) begin
            chk("out_sum", 32'(bus.out_sum), 32'(exp_sum(m_total)));
            chk("out_beats", 32'(bus.out_beats), 32'((m_n > BeatMax) ? BeatMax : m_n));
            chk("out_ovf", 32'(bus.out_ovf), 32'(m_total > AccMax));
         end
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Directed stimulus (tasks start and end just after a falling edge)
   // ---------------------------------------------------------------------------------------------
   task automatic send(input logic [47:0] ops, input bit last);
      int k;
      k = 0;
      bus.in_valid = 1'b1;
      bus.in_ops   = ops;
      bus.in_last  = last;
      while (!bus.in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20) chk("send_timeout", 32'(k), 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_ops   = '0;
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      while (!bus.out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20) chk({name, "_valid_timeout"}, 32'(k), 32'd0);
   endtask

   task automatic take(input string name, input logic [11:0] sum, input logic [1:0] beats,
                       input bit ovf);
      wait_valid(name);
      chk({name, "_sum"}, 32'(bus.out_sum), 32'(sum));
      chk({name, "_beats"}, 32'(bus.out_beats), 32'(beats));
      chk({name, "_ovf"}, 32'(bus.out_ovf), 32'(ovf));
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({name, "_ready_after_h"}, 32'(bus.in_ready), 32'd1);
      chk({name, "_valid_after_h"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks      = 0;
      n_pass        = 0;
      clk           = 1'b0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_ops    = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk("reset_beats", 32'(bus.out_beats), 32'd0);
      chk("reset_ovf", 32'(bus.out_ovf), 32'd0);
      #1 rst_n = 1'b1;
      chk("ready_before_first_edge", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      chk("ready_after_first_edge", 32'(bus.in_ready), 32'd1);

      // Single all-0xFF beat and its latency.
      send(OpsFf, 1'b1);
      chk("flush_valid_low", 32'(bus.out_valid), 32'd0);
      chk("flush_ready_low", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      chk("valid_at_e_plus_1", 32'(bus.out_valid), 32'd1);
      take("single", 12'h5FA, 2'd1, 1'b0);

      // Three beats with bubbles, then backpressure in the hold state.
      send(OpsSeq, 1'b0);
      repeat (2) @(negedge clk);
      send(OpsSeq, 1'b0);
      @(negedge clk);
      send(OpsSeq, 1'b1);
      wait_valid("bp");
      repeat (5) begin
         @(negedge clk);
         chk("bp_sum_stable", 32'(bus.out_sum), 32'h03F);
         chk("bp_ready_low", 32'(bus.in_ready), 32'd0);
      end
      take("three", 12'h03F, 2'd3, 1'b0);

      // First beat of the next frame goes in at H+1 and excludes the previous frame.
      send(OpsTen, 1'b1);
      take("after_bp", 12'h00A, 2'd1, 1'b0);

      // Back-to-back overflowing beats: 3 x 1530 = 4590.
      send(OpsFf, 1'b0);
      send(OpsFf, 1'b0);
      send(OpsFf, 1'b1);
      take("overflow", OvfSum, 2'd3, 1'b1);
      send(OpsSeq, 1'b1);
      take("ovf_cleared", 12'h015, 2'd1, 1'b0);

      // Beat counter saturation.
      repeat (4) send('0, 1'b0);
      send('0, 1'b1);
      take("beat_sat", 12'h000, 2'd3, 1'b0);

      // Reset in the middle of beat 2.
      send(OpsSeq, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_ops   = OpsSeq;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ready", 32'(bus.in_ready), 32'd0);
      chk("midrst_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_sum", 32'(bus.out_sum), 32'd0);
      chk("midrst_beats", 32'(bus.out_beats), 32'd0);
      chk("midrst_ovf", 32'(bus.out_ovf), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_ops   = '0;
      chk("midrst_ready_held", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      chk("midrst_ready_back", 32'(bus.in_ready), 32'd1);
      chk("midrst_no_valid", 32'(bus.out_valid), 32'd0);
      send(OpsOne, 1'b1);
      take("after_rst", 12'h006, 2'd1, 1'b0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gpc_accumulator.md
# gpc_accumulator

Streaming multi-operand accumulator built on generalised-parallel-counter (GPC) compression. Each accepted beat carries `N_OPS` unsigned operands. A GPC tree reduces them to carry-save form in one pipeline stage, and a carry-propagate stage folds the result into a running frame accumulator. The block sits between operand producers (dot-product and popcount datapaths) and result consumers. It is the parametrised, pipelined, handshaked successor to the fixed single-column counters.

## Interface
Parameters:
- `N_OPS`, 6: operands per beat; legal range 2..16.
- `OP_W`, 8: operand width, unsigned.
- `ACC_W`, 24: accumulator width. Must satisfy `ACC_W >= OP_W + $clog2(N_OPS)`; elaboration error otherwise.
- `BEAT_W`, 8: width of the beat counter.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  beat present on `in_ops`.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_ops`  in  N_OPS*OP_W  packed operands; operand i is at `[i*OP_W +: OP_W]`.
- `in_last`  in  1  beat is the final beat of the frame.
- `out_valid`  out  1  frame result available.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  ACC_W  frame sum.
- `out_beats`  out  BEAT_W  number of beats accepted in the frame, saturating at all-ones.
- `out_ovf`  out  1  sticky flag: the accumulator carried out of `ACC_W` during the frame.

## Operation
- A beat is accepted on any rising edge with `in_valid && in_ready`.
- Stage 1 compresses the accepted beat's operands through the GPC tree and registers a sum/carry vector pair of `OP_W + $clog2(N_OPS)` bits. The tree topology is free; only the arithmetic result is specified.
- Stage 2 adds the pair to the accumulator modulo 2^ACC_W and increments the beat counter.
- `out_ovf` is set on any carry out of bit `ACC_W-1`. It clears only on a result handshake or on reset.
- FSM states:
  - INIT: reset state. Moves to ACCUM on the first edge after `rst_n` rises.
  - ACCUM: `in_ready`=1. Accepting a beat with `in_last`=1 moves to FLUSH.
  - FLUSH: `in_ready`=0 for one cycle while stage 2 absorbs the last beat. Moves to HOLD.
  - HOLD: `out_valid`=1 and `in_ready`=0. On `out_ready`=1, clears the accumulator, beat counter and `out_ovf`, then moves to ACCUM.
- Bubbles (`in_valid`=0) in ACCUM do not alter the accumulator.
- `in_last` is ignored when `in_valid`=0.
- A frame with `BEAT_W` overflow keeps `out_beats` at all-ones. The sum stays exact modulo 2^ACC_W.
- `out_sum`, `out_beats` and `out_ovf` are driven from registers. They hold stable throughout HOLD.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_sum`=0, `out_beats`=0, `out_ovf`=0.
- Pipeline registers and accumulator clear asynchronously when `rst_n` falls.
- `in_ready` first reads 1 in the cycle after the first rising edge following `rst_n` deassertion.
- Latency: for `in_last` accepted at edge E, FLUSH occupies cycle E..E+1 and `out_valid` is high from edge E+1.
- Throughput: one beat per cycle within a frame. Inter-frame gap is at least 2 cycles (FLUSH plus the handshake edge).
- Result handshake at edge H: `out_valid` falls and `in_ready` rises after H. The first beat of the next frame can be accepted at H+1.
- Reset mid-frame: all partial state is discarded. No `out_valid` is produced for the interrupted frame.
- All outputs are registered. There is no combinational path from `in_*` or `out_ready` to any output.

## Configuration
- Macro: `GPC_ACC_SAT_EN`.
- Defined: on carry out of `ACC_W`, the accumulator clamps to all-ones and stays there for the rest of the frame. `out_ovf` is set as normal.
- Undefined: the accumulator wraps modulo 2^ACC_W. `out_ovf` is set as normal.

## Test plan
- Single beat: N_OPS=6, OP_W=8, all operands 0xFF, `in_last`=1 → `out_sum`=0x0005FA, `out_beats`=1, `out_ovf`=0, `out_valid` from edge E+1.
- Three beats of operands {1,2,3,4,5,6}, random `in_valid` bubbles between them → `out_sum`=0x00003F, `out_beats`=3.
- Backpressure: hold `out_ready`=0 for 5 cycles in HOLD → `out_sum` and `out_valid` stable, `in_ready`=0 throughout. The next frame's first beat is accepted at H+1 and that frame's sum excludes prior data.
- Overflow: ACC_W=12, three beats of all-0xFF (3×1530=4590) → without the macro, `out_sum`=0x1EE and `out_ovf`=1. With `GPC_ACC_SAT_EN`, `out_sum`=0xFFF and `out_ovf`=1.
- Reset mid-frame: pulse `rst_n` low during beat 2 of a frame → all outputs 0 immediately, `in_ready` returns after one edge. A subsequent one-beat frame of {1,1,1,1,1,1} gives `out_sum`=6.
- Beat saturation: BEAT_W=2, five beats of zeros → `out_beats`=3, `out_sum`=0.
